// File: rtl/word_splitter_pkg.sv
// Shared types and constants for the word splitter: the output FSM state
// encoding, the byte/word widths and a small byte-select helper.
package word_splitter_pkg;

   localparam int BYTE_W = 8;
   localparam int WORD_W = 16;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      FIRST  = 2'd1,
      SECOND = 2'd2
   } state_e;

   // Returns the high byte of a word when 'high' is set, else the low byte.
   function automatic logic [BYTE_W-1:0] pick_byte(input logic [WORD_W-1:0] word,
                                                   input logic              high);
      return high ? word[WORD_W-1:BYTE_W] : word[BYTE_W-1:0];
   endfunction

endpackage

// File: rtl/word_splitter_fifo.sv
// Word FIFO for the splitter: circular storage with wrapping read/write
// pointers and a separate occupancy count that saturates at DEPTH, so full
// and empty are always unambiguous.
module word_splitter_fifo #(
   parameter int DEPTH  = 4,
   parameter int WORD_W = 16,
   localparam int PTR_W = $clog2(DEPTH),
   localparam int LVL_W = PTR_W + 1
) (
   input  logic              clk_i,
   input  logic              rst_n,
   input  logic              push_i,
   input  logic [WORD_W-1:0] data_i,
   input  logic              pop_i,
   output logic [WORD_W-1:0] data_o,
   output logic              full_o,
   output logic              empty_o,
   output logic [LVL_W-1:0]  level_o
);

   logic [WORD_W-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
   logic [LVL_W-1:0]  count_q, count_d;
   logic              push_ok;
   logic              pop_ok;

   assign full_o  = (count_q == LVL_W'(DEPTH));
   assign empty_o = (count_q == '0);
   assign level_o = count_q;
   assign data_o  = mem_q[rd_ptr_q];

   // Qualify requests against full/empty and work out the next pointers and count.
   always_comb begin
      push_ok  = push_i && !full_o;
      pop_ok   = pop_i && !empty_o;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push_ok) begin
         wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
      if (pop_ok) begin
         rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      unique case ({push_ok, pop_ok})
         2'b10:   count_d = count_q + LVL_W'(1);
         2'b01:   count_d = count_q - LVL_W'(1);
         default: count_d = count_q;
      endcase
   end

   // Pointer and count registers; cleared immediately by reset.
   always_ff @(posedge clk_i or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage array; contents are don't-care until written, so it carries no reset.
   always_ff @(posedge clk_i) begin
      if (push_ok) begin
         mem_q[wr_ptr_q] <= data_i;
      end
   end

endmodule

// File: rtl/word_splitter.sv
// Splits a stream of 16-bit words into a stream of bytes. Words are buffered
// in a small FIFO; an output FSM pulls one word at a time into a hold
// register and presents its two bytes, ordered by MSB_FIRST, on a registered
// valid/ready byte interface.
module word_splitter
   import word_splitter_pkg::*;
#(
   parameter int DEPTH     = 4,
   parameter bit MSB_FIRST = 1'b0
) (
   input  logic                       clk_i,
   input  logic                       rst_n,
   input  logic                       word_valid_i,
   input  logic [15:0]                word_i,
   output logic                       word_ready_o,
   output logic                       byte_valid_o,
   output logic [7:0]                 byte_o,
   input  logic                       byte_ready_i,
   output logic [$clog2(DEPTH):0]     level_o
);

   state_e            state_q, state_d;
   logic [WORD_W-1:0] hold_q, hold_d;
   logic [BYTE_W-1:0] byte_q, byte_d;
   logic              valid_q, valid_d;

   logic [WORD_W-1:0] fifo_head;
   logic              fifo_full;
   logic              fifo_empty;
   logic              fifo_pop;

   word_splitter_fifo #(
      .DEPTH  (DEPTH),
      .WORD_W (WORD_W)
   ) u_fifo (
      .clk_i   (clk_i),
      .rst_n   (rst_n),
      .push_i  (word_valid_i),
      .data_i  (word_i),
      .pop_i   (fifo_pop),
      .data_o  (fifo_head),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .level_o (level_o)
   );

   assign word_ready_o = !fifo_full;
   assign byte_valid_o = valid_q;
   assign byte_o       = byte_q;

   // Next-state logic: load a word from the FIFO whenever the output stage is
   // free (IDLE, or SECOND being consumed) so back-to-back words leave no bubble.
   always_comb begin
      state_d  = state_q;
      hold_d   = hold_q;
      byte_d   = byte_q;
      valid_d  = valid_q;
      fifo_pop = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (!fifo_empty) begin
               fifo_pop = 1'b1;
               hold_d   = fifo_head;
               byte_d   = pick_byte(fifo_head, MSB_FIRST);
               valid_d  = 1'b1;
               state_d  = FIRST;
            end
         end
         FIRST: begin
            if (byte_ready_i) begin
               byte_d  = pick_byte(hold_q, !MSB_FIRST);
               state_d = SECOND;
            end
         end
         SECOND: begin
            if (byte_ready_i) begin
               if (!fifo_empty) begin
                  fifo_pop = 1'b1;
                  hold_d   = fifo_head;
                  byte_d   = pick_byte(fifo_head, MSB_FIRST);
                  state_d  = FIRST;
               end else begin
                  valid_d = 1'b0;
                  state_d = IDLE;
               end
            end
         end
         default: begin
            valid_d = 1'b0;
            state_d = IDLE;
         end
      endcase
   end

   // Output FSM, hold register and registered byte outputs.
   always_ff @(posedge clk_i or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         hold_q  <= '0;
         byte_q  <= '0;
         valid_q <= 1'b0;
      end else begin
         state_q <= state_d;
         hold_q  <= hold_d;
         byte_q  <= byte_d;
         valid_q <= valid_d;
      end
   end

endmodule

// File: tb/tb_word_splitter.sv
// Directed testbench for word_splitter: two instances (low-byte-first and
// high-byte-first) driven by the same stimulus, with hand-computed expected
// bytes, levels and handshake values.
module tb_word_splitter;

   logic        clk_i = 1'b0;
   logic        rst_n = 1'b0;
   logic        word_valid_i = 1'b0;
   logic [15:0] word_i = 16'h0000;
   logic        byte_ready_i = 1'b0;

   logic        word_ready_o;
   logic        byte_valid_o;
   logic [7:0]  byte_o;
   logic [2:0]  level_o;

   logic        msb_word_ready_o;
   logic        msb_byte_valid_o;
   logic [7:0]  msb_byte_o;
   logic [2:0]  msb_level_o;

   int checkCount = 0;
   int errorCount = 0;

   always #5 clk_i = ~clk_i;

   word_splitter #(.DEPTH(4), .MSB_FIRST(1'b0)) u_dut (
      .clk_i        (clk_i),
      .rst_n        (rst_n),
      .word_valid_i (word_valid_i),
      .word_i       (word_i),
      .word_ready_o (word_ready_o),
      .byte_valid_o (byte_valid_o),
      .byte_o       (byte_o),
      .byte_ready_i (byte_ready_i),
      .level_o      (level_o)
   );

   word_splitter #(.DEPTH(4), .MSB_FIRST(1'b1)) u_dut_msb (
      .clk_i        (clk_i),
      .rst_n        (rst_n),
      .word_valid_i (word_valid_i),
      .word_i       (word_i),
      .word_ready_o (msb_word_ready_o),
      .byte_valid_o (msb_byte_valid_o),
      .byte_o       (msb_byte_o),
      .byte_ready_i (byte_ready_i),
      .level_o      (msb_level_o)
   );

   // Count one comparison and report it if observed differs from expected.
   task automatic checkOutput(input string tag, input logic [31:0] actual,
                              input logic [31:0] expected);
      checkCount++;
      if (actual !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, actual, expected, $time);
      end
   endtask

   // Drive the upstream word and the downstream ready.
   task automatic applyStimulus(input logic valid, input logic [15:0] word, input logic ready);
      word_valid_i = valid;
      word_i       = word;
      byte_ready_i = ready;
   endtask

   // Advance one rising edge and settle just after it.
   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   // Reset both instances from mid-cycle and release away from the edge.
   task automatic doReset();
      applyStimulus(1'b0, 16'h0000, 1'b0);
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
   endtask

   function automatic logic [15:0] streamWord(input int k);
      logic [7:0] hi;
      logic [7:0] lo;
      hi = 8'hA0 + 8'(k);
      lo = 8'h10 + 8'(k);
      return {hi, lo};
   endfunction

   initial begin
      logic [7:0] expBytes [16];
      int         maxLevel;

      // Reset state, observed while reset is held.
      #2;
      checkOutput("rst_valid", 32'(byte_valid_o), 32'd0);
      checkOutput("rst_byte", 32'(byte_o), 32'h00);
      checkOutput("rst_level", 32'(level_o), 32'd0);
      checkOutput("rst_word_ready", 32'(word_ready_o), 32'd1);
      tick();
      rst_n = 1'b1;

      // Single word, low byte first.
      applyStimulus(1'b1, 16'hA55A, 1'b1);
      tick();
      checkOutput("single_level_after_push", 32'(level_o), 32'd1);
      checkOutput("single_not_yet_valid", 32'(byte_valid_o), 32'd0);
      applyStimulus(1'b0, 16'h0000, 1'b1);
      tick();
      checkOutput("single_b0_valid", 32'(byte_valid_o), 32'd1);
      checkOutput("single_b0", 32'(byte_o), 32'h5A);
      checkOutput("single_level_after_pop", 32'(level_o), 32'd0);
      tick();
      checkOutput("single_b1_valid", 32'(byte_valid_o), 32'd1);
      checkOutput("single_b1", 32'(byte_o), 32'hA5);
      tick();
      checkOutput("single_idle", 32'(byte_valid_o), 32'd0);

      // Backpressure holds the first byte stable.
      applyStimulus(1'b1, 16'h1234, 1'b0);
      tick();
      applyStimulus(1'b0, 16'h0000, 1'b0);
      tick();
      for (int i = 0; i < 5; i++) begin
         checkOutput("bp_hold_valid", 32'(byte_valid_o), 32'd1);
         checkOutput("bp_hold_byte", 32'(byte_o), 32'h34);
         tick();
      end
      checkOutput("bp_still_34", 32'(byte_o), 32'h34);
      applyStimulus(1'b0, 16'h0000, 1'b1);
      tick();
      checkOutput("bp_second_valid", 32'(byte_valid_o), 32'd1);
      checkOutput("bp_second_byte", 32'(byte_o), 32'h12);
      tick();
      checkOutput("bp_idle", 32'(byte_valid_o), 32'd0);

      // Fill: first word goes to the hold register (push and pop on the same
      // edge keep the level at 1), the next four fill the FIFO.
      begin
         int expLevel [5] = '{1, 1, 2, 3, 4};
         for (int w = 1; w <= 5; w++) begin
            applyStimulus(1'b1, 16'(w), 1'b0);
            tick();
            checkOutput("full_level", 32'(level_o), 32'(expLevel[w-1]));
         end
      end
      applyStimulus(1'b0, 16'h0000, 1'b0);
      checkOutput("full_word_ready", 32'(word_ready_o), 32'd0);
      applyStimulus(1'b1, 16'h00FF, 1'b0);
      tick();
      checkOutput("full_push_blocked", 32'(level_o), 32'd4);
      applyStimulus(1'b0, 16'h0000, 1'b1);
      for (int k = 0; k < 10; k++) begin
         checkOutput("drain_valid", 32'(byte_valid_o), 32'd1);
         checkOutput("drain_byte", 32'(byte_o), (k % 2 == 0) ? 32'(k / 2 + 1) : 32'h00);
         tick();
      end
      checkOutput("drain_idle", 32'(byte_valid_o), 32'd0);
      checkOutput("drain_level", 32'(level_o), 32'd0);
      checkOutput("drain_word_ready", 32'(word_ready_o), 32'd1);

      // Streaming: one word per two byte slots keeps the byte stream
      // continuous while the FIFO never holds more than one word.
      for (int k = 0; k < 8; k++) begin
         expBytes[2*k]   = streamWord(k)[7:0];
         expBytes[2*k+1] = streamWord(k)[15:8];
      end
      maxLevel = 0;
      for (int c = 0; c < 18; c++) begin
         if (c % 2 == 0 && c < 16) begin
            applyStimulus(1'b1, streamWord(c / 2), 1'b1);
         end else begin
            applyStimulus(1'b0, 16'h0000, 1'b1);
         end
         tick();
         if (int'(level_o) > maxLevel) maxLevel = int'(level_o);
         if (c >= 1 && c <= 16) begin
            checkOutput("stream_valid", 32'(byte_valid_o), 32'd1);
            checkOutput("stream_byte", 32'(byte_o), 32'(expBytes[c-1]));
         end
      end
      checkOutput("stream_idle", 32'(byte_valid_o), 32'd0);
      checkOutput("stream_level_max", 32'(maxLevel), 32'd1);

      // Reset while in SECOND with two words queued.
      applyStimulus(1'b1, 16'h1111, 1'b0);
      tick();
      applyStimulus(1'b1, 16'h2222, 1'b0);
      tick();
      applyStimulus(1'b1, 16'h3333, 1'b0);
      tick();
      applyStimulus(1'b0, 16'h0000, 1'b1);
      tick();
      applyStimulus(1'b0, 16'h0000, 1'b0);
      checkOutput("midrst_pre_byte", 32'(byte_o), 32'h11);
      checkOutput("midrst_pre_level", 32'(level_o), 32'd2);
      #2;
      rst_n = 1'b0;
      #1;
      checkOutput("midrst_valid", 32'(byte_valid_o), 32'd0);
      checkOutput("midrst_byte", 32'(byte_o), 32'h00);
      checkOutput("midrst_level", 32'(level_o), 32'd0);
      checkOutput("midrst_word_ready", 32'(word_ready_o), 32'd1);
      tick();
      rst_n = 1'b1;
      applyStimulus(1'b1, 16'hBEEF, 1'b1);
      tick();
      applyStimulus(1'b0, 16'h0000, 1'b1);
      tick();
      checkOutput("postrst_b0", 32'(byte_o), 32'hEF);
      checkOutput("postrst_b0_valid", 32'(byte_valid_o), 32'd1);
      tick();
      checkOutput("postrst_b1", 32'(byte_o), 32'hBE);
      tick();
      checkOutput("postrst_idle", 32'(byte_valid_o), 32'd0);
      checkOutput("postrst_level", 32'(level_o), 32'd0);

      // High-byte-first instance.
      doReset();
      applyStimulus(1'b1, 16'hCAFE, 1'b1);
      tick();
      checkOutput("msb_word_ready", 32'(msb_word_ready_o), 32'd1);
      checkOutput("msb_level", 32'(msb_level_o), 32'd1);
      applyStimulus(1'b0, 16'h0000, 1'b1);
      tick();
      checkOutput("msb_b0_valid", 32'(msb_byte_valid_o), 32'd1);
      checkOutput("msb_b0", 32'(msb_byte_o), 32'hCA);
      checkOutput("lsb_b0", 32'(byte_o), 32'hFE);
      tick();
      checkOutput("msb_b1", 32'(msb_byte_o), 32'hFE);
      checkOutput("lsb_b1", 32'(byte_o), 32'hCA);
      tick();
      checkOutput("msb_idle", 32'(msb_byte_valid_o), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
      $finish;
   end

endmodule

// File: doc/word_splitter.md
WORD_SPLITTER -- requirements
Module: word_splitter

Interface
REQ-001 SHALL have parameter DEPTH, default 4, word FIFO entries, power of two, >= 2.
REQ-002 SHALL have parameter MSB_FIRST, default 0: 0 emits low byte first; 1 emits high byte first.
REQ-003 SHALL have port clk_i  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port word_valid_i  input  1  upstream word present.
REQ-006 SHALL have port word_i  input  16  upstream data word.
REQ-007 SHALL have port word_ready_o  output  1  block can accept a word.
REQ-008 SHALL have port byte_valid_o  output  1  byte_o holds a valid byte.
REQ-009 SHALL have port byte_o  output  8  downstream byte.
REQ-010 SHALL have port byte_ready_i  input  1  downstream accepts byte.
REQ-011 SHALL have port level_o  output  $clog2(DEPTH)+1  words currently held in the FIFO, excluding the output stage.

Function
REQ-012 SHALL accept a word on a rising edge with word_valid_i=1 and word_ready_o=1; word_ready_o = (level_o != DEPTH), from registered state only.
REQ-013 SHALL transfer a byte on a rising edge with byte_valid_o=1 and byte_ready_i=1; byte_o and byte_valid_o SHALL be registered and SHALL stay stable while byte_valid_o=1 and byte_ready_i=0.
REQ-014 SHALL run an output FSM with states IDLE, FIRST, SECOND; byte_valid_o=1 exactly in FIRST and SECOND.
REQ-015 IDLE -> FIRST when FIFO non-empty: pop head word into a 16-bit hold register; byte_o = first byte per MSB_FIRST.
REQ-016 FIRST -> SECOND on byte transfer; byte_o = the other byte.
REQ-017 SECOND on byte transfer: -> FIRST loading the next word if FIFO non-empty (no bubble), else -> IDLE.
REQ-018 Latency: word written at edge N into an empty FIFO with FSM IDLE SHALL give byte_valid_o=1 after edge N+1.
REQ-019 A simultaneous FIFO push and pop SHALL keep level_o unchanged; push when full SHALL not occur because word_ready_o=0.
REQ-020 FIFO pointers SHALL wrap modulo DEPTH; level_o SHALL range 0..DEPTH and never wrap.
REQ-021 Sustained throughput SHALL be one byte per cycle while byte_ready_i=1 and words are available; word acceptance SHALL not stall when level_o < DEPTH.
REQ-022 Words SHALL emerge in acceptance order; no word SHALL be dropped or duplicated.

Reset
REQ-023 rst_n=0 SHALL immediately force: FSM IDLE, byte_valid_o=0, byte_o=8'h00, level_o=0, word_ready_o=1, pointers 0, hold register 16'h0000.
REQ-024 Reset asserted mid-word SHALL discard the pending second byte and all FIFO contents; after release, first accepted word SHALL start from its first byte.
REQ-025 Deassertion SHALL be synchronised by the integrating level; the block SHALL accept words on the first edge after rst_n rises.

Structure
REQ-026 Package word_splitter_pkg SHALL hold the FSM state enum (IDLE, FIRST, SECOND) and constants BYTE_W=8, WORD_W=16.
REQ-027 FIFO storage, pointers and count SHALL be one sub-module word_splitter_fifo (parameters DEPTH, WORD_W; push/pop/full/empty/level); FSM and hold register in word_splitter.

Verification
REQ-028 Single word: push 16'hA55A, byte_ready_i=1, MSB_FIRST=0 -> bytes 8'h5A then 8'hA5 on consecutive cycles, first valid one cycle after push; then IDLE.
REQ-029 Backpressure: push 16'h1234, hold byte_ready_i=0 for 5 cycles -> byte_o stable 8'h34, byte_valid_o=1; release -> 8'h34, 8'h12.
REQ-030 Full: byte_ready_i=0, push 16'h0001..16'h0005 (DEPTH=4) -> first word enters hold register, words 2..5 fill FIFO, level_o=4, word_ready_o=0; drain -> bytes 01,00,02,00,...,05,00 in order.
REQ-031 Streaming: push 8 words back-to-back, byte_ready_i=1 -> 16 bytes on 16 consecutive cycles, no gap, level_o never exceeds 1.
REQ-032 Reset mid-operation: assert rst_n=0 while in SECOND with level_o=2 -> outputs per REQ-023 same cycle; after release, push 16'hBEEF -> 8'hEF, 8'hBE only.
REQ-033 MSB_FIRST=1: push 16'hCAFE -> 8'hCA then 8'hFE.
